conv_pool_buffer: RTL

Parametrised per-channel feature-map buffer for the convolution output stage. It accepts biased, saturated convolution results, then runs a sequential 2x2 stride-2 max-pool with ReLU in place across all channels in parallel. It exposes a registered read port so the next layer can fetch pooled data. It generalises the fixed 16-channel, 14x14 layer-2 buffer to arbitrary channel count, map size and widths, and adds a handshaked, single-read-per-bank pooling engine.

---
 rtl/conv_pool_buffer_if.sv | 48 ++++
 rtl/conv_pool_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_buffer_if.sv
// conv_pool_buffer_if
//   Bundles the store, pool-control and read-port signals of conv_pool_buffer.
//   master : the client side (next layer / conv engine) driving requests
//   slave  : the buffer itself
//   Store  : store_en, store_ch, store_addr, store_val, store_bias -> store_err
//   Pool   : pool_start -> pool_busy, pool_done
//   Read   : rd_en, rd_ch, rd_addr -> rd_data, rd_valid
interface conv_pool_buffer_if #(
  parameter int DW    = 8,
  parameter int ACC_W = 16,
  parameter int AW    = 8,
  parameter int CW    = 4
);
  logic                    store_en;
  logic [CW-1:0]           store_ch;
  logic [AW-1:0]           store_addr;
  logic signed [ACC_W-1:0] store_val;
  logic signed [DW-1:0]    store_bias;
  logic                    store_err;

  logic                    pool_start;
  logic                    pool_busy;
  logic                    pool_done;

  logic                    rd_en;
  logic [CW-1:0]           rd_ch;
  logic [AW-1:0]           rd_addr;
  logic signed [DW-1:0]    rd_data;
  logic                    rd_valid;

  modport master (
    output store_en, store_ch, store_addr, store_val, store_bias,
    input  store_err,
    output pool_start,
    input  pool_busy, pool_done,
    output rd_en, rd_ch, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  store_en, store_ch, store_addr, store_val, store_bias,
    output store_err,
    input  pool_start,
    output pool_busy, pool_done,
    input  rd_en, rd_ch, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/conv_pool_buffer.sv
// conv_pool_buffer
//   Per-channel feature-map buffer for the convolution output stage. Conv
//   results are biased, saturated to DW bits and stored one element at a
//   time. A pool_start then runs an in-place 2x2 stride-2 max-pool with ReLU
//   over every channel in lockstep, leaving the pooled map packed row-major
//   at the bottom of each bank. A registered read port serves the next layer.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-low reset
//     bus  : conv_pool_buffer_if.slave (store / pool control / read port)
module conv_pool_buffer #(
  parameter int DW    = 8,
  parameter int ACC_W = 16,
  parameter int OC    = 16,
  parameter int MAP_W = 14,
  parameter int MAP_H = 14,
  parameter int AW    = $clog2(MAP_W*MAP_H),
  parameter int CW    = (OC > 1) ? $clog2(OC) : 1
) (
  input logic             clk,
  input logic             rst,
  conv_pool_buffer_if.slave bus
);

  localparam int DEPTH = MAP_W * MAP_H;
  localparam int OW    = MAP_W / 2;
  localparam int OH    = MAP_H / 2;

  localparam logic [AW-1:0] ROW_STEP = AW'(2 * MAP_W);
  localparam logic [AW-1:0] COL_STEP = AW'(2);
  localparam logic [AW-1:0] OFF_DOWN = AW'(MAP_W);
  localparam logic [AW-1:0] OW_A     = AW'(OW);
  localparam logic [AW-1:0] LAST_R   = AW'(OH - 1);
  localparam logic [AW-1:0] LAST_C   = AW'(OW - 1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [CW:0]   OC_L     = (CW+1)'(OC);

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(DW-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(DW-1)));

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} pool_state_t;

  pool_state_t state, state_nxt;

  logic [1:0]           rd_idx;
  logic [AW-1:0]        win_r;
  logic [AW-1:0]        win_c;
  logic [AW-1:0]        win_base;
  logic [AW-1:0]        rd_off;
  logic [AW-1:0]        pool_addr;
  logic [AW-1:0]        out_addr;
  logic                 last_win;
  logic                 pool_rd;
  logic                 pool_wr;

  logic                 pool_busy_q;
  logic                 pool_done_q;
  logic                 store_err_q;
  logic                 rd_valid_q;
  logic signed [DW-1:0] rd_data_q;

  logic signed [ACC_W:0] val_ext;
  logic signed [ACC_W:0] bias_ext;
  logic signed [ACC_W:0] store_sum;
  logic signed [DW-1:0]  store_sat;
  logic                  store_ch_ok;
  logic                  store_addr_ok;
  logic                  store_ok;
  logic                  rd_ok;
  logic                  rd_addr_ok;

  logic signed [DW-1:0]  host_q [OC];

  assign bus.store_err = store_err_q;
  assign bus.pool_busy = pool_busy_q;
  assign bus.pool_done = pool_done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

  // Bias add is done one bit wider than the accumulator so it cannot wrap
  // before saturation.
  assign val_ext   = {bus.store_val[ACC_W-1], bus.store_val};
  assign bias_ext  = {{(ACC_W+1-DW){bus.store_bias[DW-1]}}, bus.store_bias};
  assign store_sum = val_ext + bias_ext;

  always_comb begin
    store_sat = store_sum[DW-1:0];
    if (store_sum > SAT_MAX) begin
      store_sat = SAT_MAX[DW-1:0];
    end else if (store_sum < SAT_MIN) begin
      store_sat = SAT_MIN[DW-1:0];
    end
  end

  // A store is refused while pooling owns the banks, including the cycle in
  // which a pool is being kicked off.
  assign store_ch_ok   = ({1'b0, bus.store_ch} < OC_L);
  assign store_addr_ok = ({1'b0, bus.store_addr} < DEPTH_L);
  assign store_ok      = bus.store_en && !pool_busy_q && !bus.pool_start &&
                         store_ch_ok && store_addr_ok;

  assign rd_ok      = bus.rd_en && !pool_busy_q && ({1'b0, bus.rd_ch} < OC_L);
  assign rd_addr_ok = ({1'b0, bus.rd_addr} < DEPTH_L);

  // Window geometry: base of window (r,c) and the packed destination address.
  assign win_base  = (win_r * ROW_STEP) + (win_c * COL_STEP);
  assign out_addr  = (win_r * OW_A) + win_c;
  assign pool_addr = win_base + rd_off;
  assign last_win  = (win_r == LAST_R) && (win_c == LAST_C);
  assign pool_rd   = (state == RD);
  assign pool_wr   = (state == WR);

  always_comb begin
    rd_off = '0;
    case (rd_idx)
      2'd0:    rd_off = '0;
      2'd1:    rd_off = ONE_A;
      2'd2:    rd_off = OFF_DOWN;
      default: rd_off = OFF_DOWN + ONE_A;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: four reads, one write per window, then a single DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.pool_start) state_nxt = RD;
      RD:   if (rd_idx == 2'd3) state_nxt = WR;
      WR:   state_nxt = last_win ? DONE : RD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window walker; cleared in IDLE so every pool restarts at window (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_idx <= 2'd0;
      win_r  <= '0;
      win_c  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rd_idx <= 2'd0;
          win_r  <= '0;
          win_c  <= '0;
        end
        RD: rd_idx <= rd_idx + 2'd1;
        WR: begin
          if (last_win) begin
            win_r <= '0;
            win_c <= '0;
          end else if (win_c == LAST_C) begin
            win_c <= '0;
            win_r <= win_r + ONE_A;
          end else begin
            win_c <= win_c + ONE_A;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs are registered from the FSM; pool_done therefore lands on
  // the same edge at which pool_busy drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pool_busy_q <= 1'b0;
      pool_done_q <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      pool_busy_q <= (state_nxt != IDLE);
      pool_done_q <= (state == DONE);
      store_err_q <= bus.store_en && !store_ok;
    end
  end

  // Host read port; ignored reads leave rd_data untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) begin
        rd_data_q <= rd_addr_ok ? host_q[bus.rd_ch] : '0;
      end
    end
  end

  // One bank per channel. Each bank sees at most one pool access per cycle:
  // a read during RD or the write-back during WR.
  for (genvar b = 0; b < OC; b++) begin : g_bank
    logic signed [DW-1:0] mem [DEPTH];
    logic signed [DW-1:0] pool_q;
    logic signed [DW-1:0] run_max;
    logic signed [DW-1:0] win_max;
    logic signed [DW-1:0] pool_res;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic signed [DW-1:0] wr_data;

    // pool_q holds the word issued the cycle before, so in WR it is the
    // fourth read and win_max is the full window maximum.
    always_comb begin
      win_max  = (pool_q > run_max) ? pool_q : run_max;
      pool_res = win_max[DW-1] ? '0 : win_max;
    end

    always_comb begin
      wr_en   = 1'b0;
      wr_addr = bus.store_addr;
      wr_data = store_sat;
      if (pool_wr) begin
        wr_en   = 1'b1;
        wr_addr = out_addr;
        wr_data = pool_res;
      end else if (store_ok && (bus.store_ch == CW'(b))) begin
        wr_en = 1'b1;
      end
    end

    // Memory contents survive reset on purpose.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end

    // The first returning word seeds the running max; later ones compare.
    always_ff @(posedge clk) begin
      if (pool_rd) begin
        pool_q <= mem[pool_addr];
      end
      if (pool_rd && (rd_idx != 2'd0)) begin
        run_max <= (rd_idx == 2'd1) ? pool_q : win_max;
      end
    end

    assign host_q[b] = mem[bus.rd_addr];
  end

endmodule
